logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Shares one bitwise logic unit (AND/OR/XOR/NOR over `WIDTH` bits) among `NUM_REQ` requesters with round-robin arbitration and a registered, back-pressured result port. It sits between the multi-cycle datapath clients and the single logic-op resource, so only one operation is accepted per cycle. Every result carries the ID of the requester it belongs to.

## Interface
- `WIDTH`, 32: operand/result width in bits.
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: width of requester ID.

Ports (clock and reset first):
- `Clk` in 1: single clock; all state updates on its rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `ReqValid` in `NUM_REQ`: bit i set = requester i presents an operation.
- `ReqOp` in `2*NUM_REQ`: op for requester i in bits [2i+1:2i]; 00 AND, 01 OR, 10 XOR, 11 NOR.
- `ReqA` in `WIDTH*NUM_REQ`: operand A for requester i in slice [i*WIDTH +: WIDTH].
- `ReqB` in `WIDTH*NUM_REQ`: operand B, same slicing as `ReqA`.
- `ReqReady` out `NUM_REQ`: one-hot or zero grant; bit i high = requester i accepted this cycle.
- `RespValid` out 1: result register holds a valid result.
- `RespReady` in 1: consumer accepts the result this cycle.
- `RespId` out `ID_W`: index of the requester that issued the result.
- `RespData` out `WIDTH`: computed result.
- `RespErr` out 1: the op was unsupported in this build (see Configuration).

## Operation
- FSM states:
  - EMPTY: result register free.
  - FULL: result held until drained.
- Transitions:
  - EMPTY→FULL on any accept.
  - FULL→EMPTY on `RespReady` with no same-cycle accept.
  - FULL→FULL on `RespReady` together with an accept (back-to-back).
  - FULL with no `RespReady` holds.
- Accept condition: `|ReqValid && (state==EMPTY || RespReady)`.
- `ReqReady` is purely combinational from `ReqValid`, the pointer and the state/`RespReady` condition. It never depends on its own outputs.
- Round-robin selection:
  - Search `ReqValid` starting at `rr_ptr` and ascending with wrap-around; grant the first set bit.
  - After a grant to index g, `rr_ptr` ← (g+1) mod `NUM_REQ`.
  - `rr_ptr` is unchanged when nothing is granted.
- On accept, the result is registered:
  - `RespData` = op(A_g, B_g).
  - `RespId` = g.
  - `RespErr` is set per Configuration.
- Output register contents are stable while `RespValid && !RespReady`.
- Requesters must hold Valid/Op/A/B stable until granted. The block samples operands only in the grant cycle.
- Reset mid-operation discards any held result. There is no replay.

## Timing
- Reset values: `RespValid`=0, `RespId`=0, `RespData`=0, `RespErr`=0, `rr_ptr`=0, state EMPTY.
- `ReqReady`=0 while `Rst` is asserted.
- Latency: accept at edge N, so `RespValid`=1 with the result after edge N.
- Throughput: one op per cycle while the consumer holds `RespReady`=1.
- Simultaneous drain+accept in FULL: the old result leaves and the new result loads on the same edge, so `RespValid` stays 1.
- `RespReady` while EMPTY has no effect.
- All requesters valid: each is granted once per `NUM_REQ` consecutive accepts. Worst-case wait is `NUM_REQ`-1 accepts.

## Configuration
- `LOGIC_UNIT_ARBITER_XNOR_EN`:
  - Defined: ops 10 (XOR) and 11 (NOR) are computed; `RespErr` is always 0.
  - Undefined: ops 10/11 are still accepted and arbitrated normally, but produce `RespData`=0 and `RespErr`=1. Ops 00/01 behave identically in both builds.

## Structure
- Package `logic_arb_pkg`:
  - op encoding localparams (OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11).
  - FSM state encoding (ST_EMPTY, ST_FULL).
- One sub-module, `rr_arbiter`: combinational; inputs are the request vector, pointer and enable; outputs are the one-hot grant and the grant index.
- Pointer update, operand mux, logic op and output register live in `logic_unit_arbiter`.

## Test plan
- Reset: assert `Rst` mid-FULL with `RespData`=0xFFFF0000. Required: all outputs go to 0 immediately (async), and after release the first grant goes to requester 0 when all requesters are valid.
- Single op: requester 2 issues OR, A=0x0000_00F0, B=0x0000_000F. Required: `ReqReady`=4'b0100 for one cycle; next cycle `RespValid`=1, `RespId`=2, `RespData`=0x0000_00FF.
- Fairness: all four requesters valid continuously with `RespReady`=1. Required: grant order 0,1,2,3,0,… and a result every cycle.
- Backpressure: hold `RespReady`=0 for 3 cycles after a result arrives. Required: `ReqReady`=0 throughout, and `RespData`/`RespId` stay stable. When `RespReady`=1, a drain and a new accept occur on the same edge.
- Op coverage with `LOGIC_UNIT_ARBITER_XNOR_EN` defined: A=0xA5A5A5A5, B=0x0F0F0F0F. Required:
  - AND → 0x05050505
  - OR → 0xAFAFAFAF
  - XOR → 0xAAAAAAAA
  - NOR → 0x50505050
  - `RespErr`=0 for all four ops.
- Macro undefined: issue XOR with the same operands. Required: `RespData`=0, `RespErr`=1, and the next OR op returns 0xAFAFAFAF with `RespErr`=0.

Source files
------------

// File: rtl/logic_arb_pkg.sv
// rtl/logic_arb_pkg.sv - shared op and FSM encodings for the logic unit arbiter
package logic_arb_pkg;

  // Two-bit operation codes carried on each requester's op lane.
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // Result register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at a pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gidx
);

  // Scan from ptr upwards with wrap-around and grant the first requester found.
  // The candidate index is compared against constant loop indices so no
  // variable bit-select is needed on the request vector.
  always_comb begin
    logic             found;
    logic [ID_W:0]    cand;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (en && !found && req[i] && (cand[ID_W-1:0] == ID_W'(i))) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          gidx     = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin shared AND/OR/XOR/NOR unit with registered result (option: LOGIC_UNIT_ARBITER_XNOR_EN)
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_REQ-1:0]       ReqValid,
  input  logic [2*NUM_REQ-1:0]     ReqOp,
  input  logic [WIDTH*NUM_REQ-1:0] ReqA,
  input  logic [WIDTH*NUM_REQ-1:0] ReqB,
  output logic [NUM_REQ-1:0]       ReqReady,
  output logic                     RespValid,
  input  logic                     RespReady,
  output logic [ID_W-1:0]          RespId,
  output logic [WIDTH-1:0]         RespData,
  output logic                     RespErr
);

  state_t               state_q;
  state_t               state_d;
  logic [ID_W-1:0]      rr_ptr;
  logic                 arb_en;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      gidx;
  logic                 accept;
  logic [1:0]           op_sel;
  logic [WIDTH-1:0]     a_sel;
  logic [WIDTH-1:0]     b_sel;
  logic [WIDTH-1:0]     res_data;
  logic                 res_err;

  // A new op may enter only when the result slot is free or being drained now.
  assign arb_en    = !Rst && ((state_q == ST_EMPTY) || RespReady);
  assign accept    = |grant;
  assign ReqReady  = grant;
  assign RespValid = (state_q == ST_FULL);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req   (ReqValid),
    .ptr   (rr_ptr),
    .en    (arb_en),
    .grant (grant),
    .gidx  (gidx)
  );

  // One-hot AND-OR mux selects the granted requester's op and operands.
  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        op_sel = op_sel | ReqOp[2*i +: 2];
        a_sel  = a_sel  | ReqA[i*WIDTH +: WIDTH];
        b_sel  = b_sel  | ReqB[i*WIDTH +: WIDTH];
      end
    end
  end

  // Shared logic unit; without the XOR/NOR option those ops return zero with an error flag.
  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (op_sel)
      OP_AND: res_data = a_sel & b_sel;
      OP_OR:  res_data = a_sel | b_sel;
`ifdef LOGIC_UNIT_ARBITER_XNOR_EN
      OP_XOR: res_data = a_sel ^ b_sel;
      OP_NOR: res_data = ~(a_sel | b_sel);
`else
      OP_XOR: res_err = 1'b1;
      OP_NOR: res_err = 1'b1;
`endif
      default: res_data = '0;
    endcase
  end

  // Occupancy FSM: fill on accept, empty on drain unless refilled on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (RespReady && !accept) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Pointer moves just past the last winner so it has lowest priority next time.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      if (gidx == ID_W'(NUM_REQ-1)) rr_ptr <= '0;
      else                          rr_ptr <= gidx + ID_W'(1);
    end
  end

  // Result register loads only on accept, so it holds steady under backpressure.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      RespId   <= '0;
      RespData <= '0;
      RespErr  <= 1'b0;
    end else if (accept) begin
      RespId   <= gidx;
      RespData <= res_data;
      RespErr  <= res_err;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

  logic         Clk;
  logic         Rst;
  logic [3:0]   ReqValid;
  logic [7:0]   ReqOp;
  logic [127:0] ReqA;
  logic [127:0] ReqB;
  logic [3:0]   ReqReady;
  logic         RespValid;
  logic         RespReady;
  logic [1:0]   RespId;
  logic [31:0]  RespData;
  logic         RespErr;

  logic_unit_arbiter #(.WIDTH(32), .NUM_REQ(4)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .ReqValid  (ReqValid),
    .ReqOp     (ReqOp),
    .ReqA      (ReqA),
    .ReqB      (ReqB),
    .ReqReady  (ReqReady),
    .RespValid (RespValid),
    .RespReady (RespReady),
    .RespId    (RespId),
    .RespData  (RespData),
    .RespErr   (RespErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        err;
  } sb_t;

  typedef struct {
    int          req;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
  } vec_t;

  sb_t  sbq[$];
  vec_t vecs[6];
  int   errors = 0;
  int   checks = 0;
  int   ptr_m  = 0;
  logic full_m = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00: return {1'b0, a & b};
      2'b01: return {1'b0, a | b};
`ifdef LOGIC_UNIT_ARBITER_XNOR_EN
      2'b10: return {1'b0, a ^ b};
      default: return {1'b0, ~(a | b)};
`else
      default: return {1'b1, 32'h0};
`endif
    endcase
  endfunction

  function automatic logic [3:0] model_grant(input logic [3:0] v, input int p, input logic full,
                                             input logic rdy, output int gi);
    gi = -1;
    if (full && !rdy) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (p + k) % 4;
      if (v[j]) begin
        gi = j;
        return 4'b0001 << j;
      end
    end
    return 4'b0000;
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    ReqValid[i]        = 1'b1;
    ReqOp[2*i +: 2]    = op;
    ReqA[i*32 +: 32]   = a;
    ReqB[i*32 +: 32]   = b;
  endtask

  task automatic clear_req();
    ReqValid = '0;
    ReqOp    = '0;
    ReqA     = '0;
    ReqB     = '0;
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic cycle(input logic has_exp, input logic [32:0] exp_in);
    logic [3:0]  eg;
    logic [32:0] r;
    int          gi;
    sb_t         e;
    #3;
    eg = model_grant(ReqValid, ptr_m, full_m, RespReady, gi);
    chk("req_ready", {60'h0, ReqReady}, {60'h0, eg});
    chk("resp_valid", {63'h0, RespValid}, {63'h0, full_m});
    if (full_m) begin
      if (sbq.size() == 0) begin
        chk("sb_nonempty", 64'd0, 64'd1);
      end else begin
        e = sbq[0];
        chk("resp_id", {62'h0, RespId}, {62'h0, e.id});
        chk("resp_data", {32'h0, RespData}, {32'h0, e.data});
        chk("resp_err", {63'h0, RespErr}, {63'h0, e.err});
        if (RespReady) void'(sbq.pop_front());
      end
    end
    if (eg != 4'b0000) begin
      if (has_exp) r = exp_in;
      else         r = model_op(ReqOp[2*gi +: 2], ReqA[gi*32 +: 32], ReqB[gi*32 +: 32]);
      e.id   = 2'(gi);
      e.data = r[31:0];
      e.err  = r[32];
      sbq.push_back(e);
      ptr_m  = (gi + 1) % 4;
      full_m = 1'b1;
    end else if (RespReady) begin
      full_m = 1'b0;
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [32:0] ev;

    vecs[0] = '{req: 0, op: 2'b00, a: 32'hA5A5A5A5, b: 32'h0F0F0F0F, exp_data: 32'h05050505};
    vecs[1] = '{req: 1, op: 2'b01, a: 32'hA5A5A5A5, b: 32'h0F0F0F0F, exp_data: 32'hAFAFAFAF};
    vecs[2] = '{req: 2, op: 2'b10, a: 32'hA5A5A5A5, b: 32'h0F0F0F0F, exp_data: 32'hAAAAAAAA};
    vecs[3] = '{req: 3, op: 2'b11, a: 32'hA5A5A5A5, b: 32'h0F0F0F0F, exp_data: 32'h50505050};
    vecs[4] = '{req: 1, op: 2'b10, a: 32'hA5A5A5A5, b: 32'h0F0F0F0F, exp_data: 32'hAAAAAAAA};
    vecs[5] = '{req: 2, op: 2'b01, a: 32'hA5A5A5A5, b: 32'h0F0F0F0F, exp_data: 32'hAFAFAFAF};

    // Reset state, with all requesters asking.
    Rst = 1'b1;
    clear_req();
    ReqValid  = 4'b1111;
    RespReady = 1'b1;
    #2;
    chk("rst_req_ready", {60'h0, ReqReady}, 64'h0);
    chk("rst_resp_valid", {63'h0, RespValid}, 64'h0);
    chk("rst_resp_id", {62'h0, RespId}, 64'h0);
    chk("rst_resp_data", {32'h0, RespData}, 64'h0);
    chk("rst_resp_err", {63'h0, RespErr}, 64'h0);
    @(posedge Clk); @(posedge Clk); #1;
    Rst = 1'b0;
    clear_req();

    // Single OR from requester 2.
    set_req(2, 2'b01, 32'h000000F0, 32'h0000000F);
    #1;
    chk("single_grant", {60'h0, ReqReady}, 64'h4);
    cycle(1'b1, {1'b0, 32'h000000FF});
    clear_req();
    cycle(1'b0, 33'h0);
    cycle(1'b0, 33'h0);

    // Op table, one accept per cycle with the consumer always ready.
    for (int n = 0; n < 6; n++) begin
      clear_req();
      set_req(vecs[n].req, vecs[n].op, vecs[n].a, vecs[n].b);
`ifdef LOGIC_UNIT_ARBITER_XNOR_EN
      ev = {1'b0, vecs[n].exp_data};
`else
      ev = vecs[n].op[1] ? {1'b1, 32'h0} : {1'b0, vecs[n].exp_data};
`endif
      cycle(1'b1, ev);
    end
    clear_req();
    cycle(1'b0, 33'h0);
    cycle(1'b0, 33'h0);

    // Fairness: all four valid, result every cycle.
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 32'h1234_0000 + 32'(i), 32'h00FF_00FF);
    for (int n = 0; n < 9; n++) cycle(1'b0, 33'h0);

    // Backpressure: stall 3 cycles then drain and accept on the same edge.
    RespReady = 1'b0;
    for (int n = 0; n < 3; n++) cycle(1'b0, 33'h0);
    RespReady = 1'b1;
    cycle(1'b0, 33'h0);
    cycle(1'b0, 33'h0);
    clear_req();
    cycle(1'b0, 33'h0);
    cycle(1'b0, 33'h0);

    // Reset while holding 0xFFFF0000.
    set_req(1, 2'b01, 32'hFFFF0000, 32'h0);
    RespReady = 1'b0;
    cycle(1'b0, 33'h0);
    clear_req();
    cycle(1'b0, 33'h0);
    chk("pre_rst_data", {32'h0, RespData}, 64'hFFFF0000);
    ReqValid = 4'b1111;
    Rst = 1'b1;
    #1;
    chk("arst_resp_valid", {63'h0, RespValid}, 64'h0);
    chk("arst_resp_data", {32'h0, RespData}, 64'h0);
    chk("arst_resp_id", {62'h0, RespId}, 64'h0);
    chk("arst_resp_err", {63'h0, RespErr}, 64'h0);
    chk("arst_req_ready", {60'h0, ReqReady}, 64'h0);
    sbq.delete();
    ptr_m  = 0;
    full_m = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    RespReady = 1'b1;
    #1;
    chk("post_rst_first_grant", {60'h0, ReqReady}, 64'h1);
    cycle(1'b0, 33'h0);
    cycle(1'b0, 33'h0);

    // Random traffic against the model.
    for (int n = 0; n < 200; n++) begin
      ReqValid  = 4'($urandom_range(0, 15));
      ReqOp     = 8'($urandom);
      ReqA      = {$urandom, $urandom, $urandom, $urandom};
      ReqB      = {$urandom, $urandom, $urandom, $urandom};
      RespReady = ($urandom_range(0, 3) != 0);
      cycle(1'b0, 33'h0);
    end
    clear_req();
    RespReady = 1'b1;
    cycle(1'b0, 33'h0);
    cycle(1'b0, 33'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
